// File: rtl/servo_pkg.sv
// Shared servo PWM constants and decoder FSM state type; also used by the servo PWM generator.
package servo_pkg;

    localparam int WIDTH_W            = 20;
    localparam int UNIT_SHIFT_DEF     = 8;
    localparam int POS_OFFSET_DEF     = 165;
    localparam int TIMEOUT_CYCLES_DEF = 2097152;

    typedef enum logic [1:0] {
        ARM,
        WAIT_RISE,
        HIGH,
        DONE
    } dec_state_e;

endpackage

// File: rtl/servo_in_sync.sv
// Input conditioning for the servo decoder: 2-flop synchronizer, optional 3-sample
// majority filter (SERVO_DEC_GLITCH_EN), and edge detection against s_prev.
module servo_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic s_prev_q;
    logic s;

    // Flops reset high so a pulse already in progress at reset never looks like a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            s_prev_q <= 1'b1;
        end else begin
            sync1_q  <= pwm_i;
            sync2_q  <= sync1_q;
            s_prev_q <= s;
        end
    end

`ifdef SERVO_DEC_GLITCH_EN
    logic hist1_q;
    logic hist2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= 1'b1;
            hist2_q <= 1'b1;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
        end
    end

    assign s = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
    assign s = sync2_q;
`endif

    assign s_o    = s;
    assign rise_o = s & ~s_prev_q;
    assign fall_o = ~s & s_prev_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures pulse high time and recovers the 8-bit position.
// Optional glitch filter in servo_in_sync is enabled by SERVO_DEC_GLITCH_EN.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int POS_OFFSET     = POS_OFFSET_DEF,
    parameter int CNT_W          = WIDTH_W,
    parameter int UNIT_SHIFT     = UNIT_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_in,
    output logic [7:0] position,
    output logic       valid,
    output logic       err_range,
    output logic       lost
);

    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int UNITS_W = CNT_W - UNIT_SHIFT;

    logic s;
    logic rise;
    logic fall;

    servo_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_i  (pwm_in),
        .s_o    (s),
        .rise_o (rise),
        .fall_o (fall)
    );

    dec_state_e         state_q;
    logic [CNT_W-1:0]   width_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [7:0]         pos_q;
    logic               valid_q;
    logic               err_q;
    logic               lost_q;

    logic [UNITS_W-1:0] units;
    int                 diff;
    logic [7:0]         pos_d;
    logic               err_d;

    always_comb begin
        units = width_q[CNT_W-1:UNIT_SHIFT];
        diff  = int'(units) - POS_OFFSET;
        pos_d = 8'd0;
        err_d = 1'b0;
        if (diff < 0) begin
            pos_d = 8'd0;
            err_d = 1'b1;
        end else if (diff > 255) begin
            pos_d = 8'hFF;
            err_d = 1'b1;
        end else begin
            pos_d = diff[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARM;
            width_q <= '0;
            tmo_q   <= '0;
            pos_q   <= 8'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            // Saturating so a long HIGH phase cannot wrap past the terminal count.
            if (state_q != ARM && tmo_q != '1) tmo_q <= tmo_q + TMO_W'(1);
            if (rise) tmo_q <= '0;
            case (state_q)
                ARM: begin
                    if (!s) state_q <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        width_q <= '0;
                        state_q <= HIGH;
                    end else if (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        lost_q <= 1'b1;
                        tmo_q  <= '0;
                    end
                end
                HIGH: begin
                    if (width_q == '1) begin
                        lost_q  <= 1'b1;
                        state_q <= ARM;
                    end else begin
                        width_q <= width_q + CNT_W'(1);
                        if (fall) state_q <= DONE;
                    end
                end
                DONE: begin
                    pos_q   <= pos_d;
                    err_q   <= err_d;
                    valid_q <= 1'b1;
                    lost_q  <= 1'b0;
                    tmo_q   <= '0;
                    state_q <= WAIT_RISE;
                end
                default: state_q <= ARM;
            endcase
        end
    end

    assign position  = pos_q;
    assign valid     = valid_q;
    assign err_range = err_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder, run at a scaled time base (4 clocks per unit).
module tb_servo_pulse_decoder;

    localparam int TMO   = 3000;
    localparam int OFF   = 165;
    localparam int CW    = 12;
    localparam int SHIFT = 2;
`ifdef SERVO_DEC_GLITCH_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        logic [7:0] pos;
        logic       err;
    } frame_t;

    typedef struct {
        string      name;
        int         high;
        logic [7:0] pos;
        logic       err;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       pwm_in;
    logic [7:0] position;
    logic       valid;
    logic       err_range;
    logic       lost;

    int checks = 0;
    int errors = 0;

    frame_t got_q[$];
    frame_t exp_q[$];
    logic [7:0] prev_pos = 8'd0;
    logic       prev_valid = 1'b0;

    servo_pulse_decoder #(
        .TIMEOUT_CYCLES (TMO),
        .POS_OFFSET     (OFF),
        .CNT_W          (CW),
        .UNIT_SHIFT     (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .position  (position),
        .valid     (valid),
        .err_range (err_range),
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position from high time using the encoding high = (pos + OFF) * 2^SHIFT.
    function automatic frame_t model(input int high);
        frame_t f;
        int u;
        int d;
        u = high / (1 << SHIFT);
        d = u - OFF;
        if (d < 0)        begin f.pos = 8'd0;  f.err = 1'b1; end
        else if (d > 255) begin f.pos = 8'hFF; f.err = 1'b1; end
        else              begin f.pos = 8'(d); f.err = 1'b0; end
        return f;
    endfunction

    // Frame collector plus per-cycle strobe/hold rules.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((err_range && !valid) || (position !== prev_pos && !valid) || (valid && prev_valid)) begin
                errors++;
                $display("FAIL strobe_rules: valid=%0b prev_valid=%0b err=%0b pos=%0d prev_pos=%0d",
                         valid, prev_valid, err_range, position, prev_pos);
            end
            if (valid) got_q.push_back('{position, err_range});
        end
        prev_pos   = position;
        prev_valid = valid;
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic check_none(input string name);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d frames, want 0", name, got_q.size());
        end
        got_q.delete();
    endtask

    task automatic check_one(input string name, input logic [7:0] pos, input logic err);
        checks++;
        if (got_q.size() != 1) begin
            errors++;
            $display("FAIL %s: got %0d frames, want 1", name, got_q.size());
        end else begin
            checks++;
            if (got_q[0].pos !== pos) begin
                errors++;
                $display("FAIL %s_pos: got %0d, want %0d", name, got_q[0].pos, pos);
            end
            checks++;
            if (got_q[0].err !== err) begin
                errors++;
                $display("FAIL %s_err: got %0b, want %0b", name, got_q[0].err, err);
            end
        end
        got_q.delete();
    endtask

    // Must be called at a falling edge; returns at a falling edge.
    task automatic drive_pulse(input int high, input int low);
        pwm_in = 1'b1;
        repeat (high) @(negedge clk);
        pwm_in = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        int seen;
        int hi;
        int lo;
        frame_t f;

        vecs[0] = '{"pos0",      660, 8'd0,   1'b0};
        vecs[1] = '{"pos128",   1172, 8'd128, 1'b0};
        vecs[2] = '{"pos255",   1680, 8'd255, 1'b0};
        vecs[3] = '{"under156",  624, 8'd0,   1'b1};
        vecs[4] = '{"over429",  1716, 8'd255, 1'b1};
        vecs[5] = '{"lo_edge",   663, 8'd0,   1'b0};
        vecs[6] = '{"lo_minus",  659, 8'd0,   1'b1};
        vecs[7] = '{"hi_edge",  1683, 8'd255, 1'b0};
        vecs[8] = '{"hi_plus",  1684, 8'd255, 1'b1};
        vecs[9] = '{"pos91",    1024, 8'd91,  1'b0};

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("rst_valid", valid, 1'b0);
        check_bit("rst_err", err_range, 1'b0);
        check_bit("rst_lost", lost, 1'b1);
        checks++;
        if (position !== 8'd0) begin
            errors++;
            $display("FAIL rst_pos: got %0d, want 0", position);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // First frame: latency, lost clearing, then timeout measured from the valid strobe.
        check_bit("lost_before_frame", lost, 1'b1);
        pwm_in = 1'b1;
        repeat (660) @(negedge clk);
        pwm_in = 1'b0;
        seen = 0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (valid && seen == 0) seen = k;
        end
        checks++;
        if (seen != LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles, want %0d", seen, LAT);
        end
        check_one("first_frame", 8'd0, 1'b0);
        check_bit("lost_after_frame", lost, 1'b0);
        repeat (LAT + TMO - 1 - 7) @(posedge clk);
        #1 check_bit("lost_pre_timeout", lost, 1'b0);
        @(posedge clk);
        #1 check_bit("lost_at_timeout", lost, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_none("timeout_no_valid");
        drive_pulse(860, 20);
        check_one("tmo_recover", 8'd50, 1'b0);
        check_bit("tmo_recover_lost", lost, 1'b0);

        for (int i = 0; i < 10; i++) begin
            drive_pulse(vecs[i].high, 20);
            check_one(vecs[i].name, vecs[i].pos, vecs[i].err);
        end

        pwm_in = 1'b1;
        @(negedge clk);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
`ifdef SERVO_DEC_GLITCH_EN
        check_none("glitch");
`else
        check_one("glitch", 8'd0, 1'b1);
`endif

        pwm_in = 1'b1;
        repeat (4200) @(negedge clk);
        check_bit("stuck_lost", lost, 1'b1);
        check_none("stuck_no_valid");
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
        drive_pulse(700, 20);
        check_one("stuck_recover", 8'd10, 1'b0);
        check_bit("stuck_recover_lost", lost, 1'b0);

        pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("midrst_valid", valid, 1'b0);
        check_bit("midrst_err", err_range, 1'b0);
        check_bit("midrst_lost", lost, 1'b1);
        checks++;
        if (position !== 8'd0) begin
            errors++;
            $display("FAIL midrst_pos: got %0d, want 0", position);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (400) @(negedge clk);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
        check_none("midrst_discard");
        drive_pulse(968, 20);
        check_one("midrst_next", 8'd77, 1'b0);

        for (int i = 0; i < 30; i++) begin
            hi = int'($urandom_range(600, 1760));
            lo = int'($urandom_range(2, 40));
            exp_q.push_back(model(hi));
            drive_pulse(hi, lo);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            f = exp_q[i];
            checks++;
            if (got_q[i].pos !== f.pos || got_q[i].err !== f.err) begin
                errors++;
                $display("FAIL rand_frame%0d: got pos=%0d err=%0b, want pos=%0d err=%0b",
                         i, got_q[i].pos, got_q[i].err, f.pos, f.err);
            end
        end
        got_q.delete();
        exp_q.delete();
        check_bit("rand_lost", lost, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
